// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and RUN/HALTED control.
// Optional macro FETCH_COUNT_EN adds a saturating 16-bit count of captured instructions.
module pc_fetch_stage #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  next_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] imem_instr,
    output logic [7:0]  pc_out,
    output logic [7:0]  pc_plus1,
    output logic [31:0] ifid_instr,
    output logic [7:0]  ifid_pc1,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [7:0]  ifid_pc1_q, ifid_pc1_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halted_q, halted_d;
    logic [7:0]  pc_plus1_s;

    // Incrementer wraps modulo 256; the carry is intentionally dropped.
    assign pc_plus1_s = pc_q + 8'd1;

    // Next-state and datapath selection; flush outranks stall, and HALTED ignores both.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc1_d   = ifid_pc1_q;
        ifid_valid_d = ifid_valid_q;
        halted_d     = halted_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    pc_d         = next_pc;
                    ifid_instr_d = NOP_WORD;
                    ifid_pc1_d   = 8'h00;
                    ifid_valid_d = 1'b0;
                end else if (stall) begin
                    pc_d         = pc_q;
                    ifid_instr_d = ifid_instr_q;
                end else begin
                    ifid_instr_d = imem_instr;
                    ifid_pc1_d   = pc_plus1_s;
                    ifid_valid_d = 1'b1;
                    // The halt word itself is captured, but the PC freezes on it.
                    if (imem_instr == HALT_WORD) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            ST_HALTED: begin
                ifid_instr_d = NOP_WORD;
                ifid_valid_d = 1'b0;
                halted_d     = 1'b1;
            end
            default: begin
                state_d      = ST_RUN;
                ifid_instr_d = NOP_WORD;
                ifid_valid_d = 1'b0;
                halted_d     = 1'b0;
            end
        endcase
    end

    // State and pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_WORD;
            ifid_pc1_q   <= 8'h00;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc1_q   <= ifid_pc1_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign pc_out     = pc_q;
    assign pc_plus1   = pc_plus1_s;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc1   = ifid_pc1_q;
    assign ifid_valid = ifid_valid_q;
    assign halted     = halted_q;

`ifdef FETCH_COUNT_EN
    logic        capture_s;
    logic [15:0] fetch_count_q, fetch_count_d;

    assign capture_s = (state_q == ST_RUN) && !flush && !stall;

    // Saturating count of normal captures, halt capture included.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (capture_s && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 16'h0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: expected IF state is queued per step and checked after the edge.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [7:0]  next_pc;
    logic        stall;
    logic        flush;
    logic [31:0] imem_instr;
    logic [7:0]  pc_out;
    logic [7:0]  pc_plus1;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc1;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    logic        use_plus1;
    logic [7:0]  forced_pc;
    logic        halt_en;
    logic [7:0]  halt_pc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [7:0]  pc1;
        logic        valid;
        logic        hlt;
    } exp_t;

    exp_t sb[$];

    pc_fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .imem_instr (imem_instr),
        .pc_out     (pc_out),
        .pc_plus1   (pc_plus1),
        .ifid_instr (ifid_instr),
        .ifid_pc1   (ifid_pc1),
        .ifid_valid (ifid_valid),
        .halted     (halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory and PC-source mux models.
    always_comb begin
        if (halt_en && (pc_out == halt_pc)) imem_instr = 32'hFFFF_FFFF;
        else                                imem_instr = 32'h1000_0000 + {24'h0, pc_out};
        next_pc = use_plus1 ? pc_plus1 : forced_pc;
    end

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] pc, input logic [31:0] ins,
                        input logic [7:0] pc1, input logic v, input logic h);
        exp_t e;
        e.tag = tag; e.pc = pc; e.instr = ins; e.pc1 = pc1; e.valid = v; e.hlt = h;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk32("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk32({e.tag, ".pc"},    {24'h0, pc_out},     {24'h0, e.pc});
            chk32({e.tag, ".instr"}, ifid_instr,          e.instr);
            chk32({e.tag, ".pc1"},   {24'h0, ifid_pc1},   {24'h0, e.pc1});
            chk32({e.tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, e.valid});
            chk32({e.tag, ".halt"},  {31'h0, halted},     {31'h0, e.hlt});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        use_plus1 = 1'b1; forced_pc = 8'h00; halt_en = 1'b0; halt_pc = 8'h07;
        #12;
        push("reset", 8'h00, 32'h0, 8'h00, 1'b0, 1'b0);
        pop_check();
        chk32("reset.plus1", {24'h0, pc_plus1}, 32'h01);
`ifdef FETCH_COUNT_EN
        chk32("reset.count", {16'h0, fetch_count}, 32'h0);
`endif
        @(negedge clk); rst_n = 1'b1;

        push("run1", 8'h01, 32'h1000_0000, 8'h01, 1'b1, 1'b0); tick();
        push("run2", 8'h02, 32'h1000_0001, 8'h02, 1'b1, 1'b0); tick();
        push("run3", 8'h03, 32'h1000_0002, 8'h03, 1'b1, 1'b0); tick();
        push("run4", 8'h04, 32'h1000_0003, 8'h04, 1'b1, 1'b0); tick();
        push("run5", 8'h05, 32'h1000_0004, 8'h05, 1'b1, 1'b0); tick();

        stall = 1'b1;
        push("stall1", 8'h05, 32'h1000_0004, 8'h05, 1'b1, 1'b0); tick();
        push("stall2", 8'h05, 32'h1000_0004, 8'h05, 1'b1, 1'b0); tick();
        stall = 1'b0;
        push("unstall", 8'h06, 32'h1000_0005, 8'h06, 1'b1, 1'b0); tick();

        stall = 1'b1; flush = 1'b1; use_plus1 = 1'b0; forced_pc = 8'h40;
        push("flush_stall", 8'h40, 32'h0, 8'h00, 1'b0, 1'b0); tick();

        stall = 1'b0; forced_pc = 8'hFF;
        push("flush_ff", 8'hFF, 32'h0, 8'h00, 1'b0, 1'b0); tick();
        flush = 1'b0; use_plus1 = 1'b1;
        chk32("wrap.plus1", {24'h0, pc_plus1}, 32'h00);
        push("wrap", 8'h00, 32'h1000_00FF, 8'h00, 1'b1, 1'b0); tick();

        use_plus1 = 1'b0; forced_pc = 8'h07;
        push("jump7", 8'h07, 32'h1000_0000, 8'h01, 1'b1, 1'b0); tick();

        halt_en = 1'b1; use_plus1 = 1'b1;
        push("halt_cap", 8'h07, 32'hFFFF_FFFF, 8'h08, 1'b1, 1'b1); tick();
        push("halt_nop", 8'h07, 32'h0, 8'h08, 1'b0, 1'b1); tick();
        flush = 1'b1; use_plus1 = 1'b0; forced_pc = 8'h40;
        push("halt_flush", 8'h07, 32'h0, 8'h08, 1'b0, 1'b1); tick();
        flush = 1'b0; stall = 1'b1;
        push("halt_stall", 8'h07, 32'h0, 8'h08, 1'b0, 1'b1); tick();
        stall = 1'b0;
`ifdef FETCH_COUNT_EN
        chk32("count", {16'h0, fetch_count}, 32'd9);
`endif

        #2; rst_n = 1'b0; #1;
        push("halt_reset", 8'h00, 32'h0, 8'h00, 1'b0, 1'b0);
        pop_check();
        @(negedge clk); rst_n = 1'b1; halt_en = 1'b0; use_plus1 = 1'b1;
        push("post_reset", 8'h01, 32'h1000_0000, 8'h01, 1'b1, 1'b0); tick();

        chk32("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the 8-bit-address MIPS datapath.
- Holds the program counter and produces pc_plus1, which feeds data input 0 of the downstream PC-source 8-bit 2:1 mux.
- Registers that mux's output back as the next PC, and captures the instruction-memory word into the IF/ID pipeline register.
- Provides stall, flush and halt control.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.
- NOP_WORD, 32'h0000_0000, bubble inserted into IF/ID on flush or reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- next_pc  in  8  selected next PC from the PC-source mux.
- stall  in  1  hazard-unit hold request.
- flush  in  1  branch-taken squash request.
- imem_instr  in  32  combinational instruction-memory read data at pc_out.
- pc_out  out  8  current PC; instruction-memory address.
- pc_plus1  out  8  pc_out+1, combinational; mux input 0.
- ifid_instr  out  32  IF/ID instruction register.
- ifid_pc1  out  8  IF/ID copy of pc_plus1.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on HALT_WORD.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc_out=RESET_PC, ifid_instr=NOP_WORD, ifid_pc1=0, ifid_valid=0, halted=0.
  - State machine goes to RUN.
  - Reset asserted mid-stall, mid-flush or while HALTED overrides everything on the same cycle.
- pc_plus1 = pc_out + 1, 8-bit modulo: 8'hFF gives 8'h00. No carry out.
- FSM states are RUN and HALTED.
- RUN, priority per edge is flush > stall > normal:
  - flush=1: pc_out<=next_pc, ifid_instr<=NOP_WORD, ifid_pc1<=0, ifid_valid<=0. Flush wins over a simultaneous stall. HALT_WORD is not checked on a flush cycle.
  - stall=1, flush=0: pc_out and all IF/ID registers hold.
  - Normal: pc_out<=next_pc, ifid_instr<=imem_instr, ifid_pc1<=pc_plus1, ifid_valid<=1.
  - Normal and imem_instr==HALT_WORD: the HALT word is still captured into IF/ID with valid=1. pc_out does not advance. Next state is HALTED and halted<=1.
- HALTED:
  - pc_out holds.
  - ifid_instr<=NOP_WORD and ifid_valid<=0 on the first HALTED edge, then hold.
  - stall and flush are ignored.
  - Only reset exits HALTED.
- Latency: next_pc appears on pc_out one edge after it is sampled. The instruction at PC p appears in ifid_instr on the edge after pc_out=p, provided no stall or flush.
- Inputs are sampled only at the rising edge; no combinational path from stall or flush to any output.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined:
  - Adds output fetch_count[15:0], reset to 0.
  - Increments on every edge that performs a normal capture (ifid_valid<=1), HALT capture included.
  - Saturates at 16'hFFFF; does not wrap.
  - Stall, flush and HALTED cycles do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, next_pc driven from pc_plus1, imem returns 32'h1000_0000+pc, three edges -> pc_out=01,02,03; ifid_instr=1000_0000,1000_0001,1000_0002; ifid_pc1=01,02,03; ifid_valid=1.
- pc_out=8'hFF, next_pc=pc_plus1 -> pc_plus1=8'h00 before the edge; after the edge pc_out=00 and ifid_pc1=00.
- stall=1 for 2 cycles with pc_out=05 -> pc_out=05 and IF/ID unchanged for both cycles; on release the next edge captures the instruction at 05.
- flush=1 and stall=1 together, next_pc=8'h40 -> pc_out=40, ifid_instr=0, ifid_valid=0.
- imem_instr=FFFF_FFFF at pc 07 -> ifid_instr=FFFF_FFFF with valid=1 and halted=1, pc_out stays 07. Next edge: valid=0. Further flush pulses have no effect until rst_n low, which restores pc_out=00 and halted=0.
- With FETCH_COUNT_EN: 4 normal edges, 2 stalled, 1 flushed -> fetch_count=4. Preload to FFFE and capture 3 more -> FFFF.
